// File: rtl/vape_exec_tracker.sv
// vape_exec_tracker: consumes the per-cycle VAPE exec verdict and tracks one
// execution of the executable region ER[ER_min..ER_max]. Produces a sticky
// EXEC flag, a snapshot handshake for the attestation routine and a
// saturating violation counter.
// Optional feature macro: VAPE_VIOL_LOG_EN (logs pc / failing sub-checks of the
// first violation in the current run). Without it viol_pc/viol_src are 0.
module vape_exec_tracker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             puc,
  input  logic [15:0]      pc,
  input  logic             exec,
  input  logic [4:0]       exec_sub,
  input  logic [15:0]      ER_min,
  input  logic [15:0]      ER_max,
  input  logic             snap_req,
  input  logic             snap_ack,
  output logic             exec_flag,
  output logic             snap_vld,
  output logic             snap_flag,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [15:0]      viol_pc,
  output logic [4:0]       viol_src
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state_r;
  state_t state_nxt_s;
  logic   exec_d_r;
  logic   at_min_s;
  logic   at_max_s;
  logic   single_s;
  logic   flag_nxt_s;
  logic   run_entry_s;
  logic   viol_edge_s;

  assign at_min_s = (pc == ER_min);
  assign at_max_s = (pc == ER_max);
  assign single_s = (ER_min == ER_max);

  // State register; puc returns the tracker to IDLE from any state.
  always_ff @(posedge clk) begin
    if (puc) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a low exec dominates any pc match in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE, S_FAIL: begin
        if (at_min_s && exec) begin
          state_nxt_s = single_s ? S_DONE : S_RUN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_RUN: begin
        if (!exec) begin
          state_nxt_s = S_FAIL;
        end else if (at_max_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DONE: begin
        if (!exec) begin
          state_nxt_s = S_FAIL;
        end else if (at_min_s && !single_s) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Output decode: next flag value, run-entry event and exec falling edge.
  always_comb begin
    flag_nxt_s  = (state_nxt_s == S_DONE);
    viol_edge_s = exec_d_r && !exec;
    if ((state_nxt_s == S_RUN || state_nxt_s == S_DONE) &&
        (state_r == S_IDLE || state_r == S_FAIL ||
         (state_r == S_DONE && state_nxt_s == S_RUN))) begin
      run_entry_s = 1'b1;
    end else begin
      run_entry_s = 1'b0;
    end
  end

  // Sticky EXEC flag, registered copy of "next state is DONE".
  always_ff @(posedge clk) begin
    if (puc) begin
      exec_flag <= 1'b0;
    end else begin
      exec_flag <= flag_nxt_s;
    end
  end

  // Delayed exec and saturating count of exec 1->0 transitions.
  always_ff @(posedge clk) begin
    if (puc) begin
      exec_d_r <= 1'b1;
      viol_cnt <= {CNT_W{1'b0}};
    end else begin
      exec_d_r <= exec;
      if (viol_edge_s && (viol_cnt != CNT_MAX)) begin
        viol_cnt <= viol_cnt + CNT_ONE;
      end else begin
        viol_cnt <= viol_cnt;
      end
    end
  end

  // Snapshot handshake: capture on request when idle, release on ack.
  always_ff @(posedge clk) begin
    if (puc) begin
      snap_vld  <= 1'b0;
      snap_flag <= 1'b0;
    end else if (snap_vld) begin
      if (snap_ack) begin
        snap_vld <= 1'b0;
      end else begin
        snap_vld <= 1'b1;
      end
    end else if (snap_req) begin
      snap_vld  <= 1'b1;
      snap_flag <= exec_flag;
    end else begin
      snap_vld <= 1'b0;
    end
  end

`ifdef VAPE_VIOL_LOG_EN
  // Logger is disarmed until a run is entered; it then keeps only the first violation.
  logic viol_logged_r;

  // First-violation logger, cleared on every run entry.
  always_ff @(posedge clk) begin
    if (puc) begin
      viol_pc       <= 16'h0000;
      viol_src      <= 5'b00000;
      viol_logged_r <= 1'b1;
    end else if (run_entry_s) begin
      viol_pc       <= 16'h0000;
      viol_src      <= 5'b00000;
      viol_logged_r <= 1'b0;
    end else if (viol_edge_s && !viol_logged_r) begin
      viol_pc       <= pc;
      viol_src      <= ~exec_sub;
      viol_logged_r <= 1'b1;
    end else begin
      viol_logged_r <= viol_logged_r;
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{exec_sub, run_entry_s};
  assign viol_pc  = 16'h0000;
  assign viol_src = 5'b00000;
`endif

endmodule
